// File: rtl/hc_sr04_pkg.sv
// Shared FSM encoding, channel-index width helper and default 50 MHz timing
// for the multi-channel HC-SR04 scanner.
package hc_sr04_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_t;

   localparam int DEF_TRIG_CYCLES  = 500;
   localparam int DEF_SLOT_CYCLES  = 3_000_000;
   localparam int DEF_RISE_TIMEOUT = 50_000;
   localparam int DEF_ECHO_TIMEOUT = 1_900_000;
   localparam int DEF_BAR_STEP     = 5_882;

   // A single sensor still needs a 1-bit channel index.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hc_sr04_scanner_if.sv
// Sensor GPIO, per-channel results and bar-graph signals of the scanner,
// seen from the scanner (master) and from the radar top level (slave).
interface hc_sr04_scanner_if
   import hc_sr04_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int RANGE_W  = 22,
   parameter int BAR_LEDS = 18
);
   localparam int CH_W = ch_width(CHANNELS);

   logic                         enable;
   logic [CHANNELS-1:0]          echo;
   logic [CHANNELS-1:0]          trigger;
   logic [CHANNELS*RANGE_W-1:0]  range_flat;
   logic [CHANNELS-1:0]          valid;
   logic [CHANNELS-1:0]          timeout;
   logic                         done;
   logic [CH_W-1:0]              done_ch;
   logic                         busy;
   logic [CH_W-1:0]              bar_sel;
   logic [BAR_LEDS-1:0]          bar;

   modport master (
      input  enable, echo, bar_sel,
      output trigger, range_flat, valid, timeout, done, done_ch, busy, bar
   );

   modport slave (
      output enable, echo, bar_sel,
      input  trigger, range_flat, valid, timeout, done, done_ch, busy, bar
   );

endinterface

// File: rtl/hc_sr04_bar.sv
// Registered thermometer bar: LED k lights when the range is at least k*BAR_STEP,
// so a valid result always lights LED 0.
module hc_sr04_bar #(
   parameter int RANGE_W  = 22,
   parameter int BAR_LEDS = 18,
   parameter int BAR_STEP = 5_882
)(
   input  logic                clock,
   input  logic                reset,
   input  logic [RANGE_W-1:0]  range_in,
   input  logic                valid_in,
   output logic [BAR_LEDS-1:0] bar
);
   logic [63:0]         range_ext;
   logic [BAR_LEDS-1:0] bar_d;

   assign range_ext = 64'(range_in);

   for (genvar k = 0; k < BAR_LEDS; k++) begin : g_thr
      localparam logic [63:0] THR = 64'(k) * 64'(BAR_STEP);
      assign bar_d[k] = valid_in && (range_ext >= THR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) bar <= '0;
      else       bar <= bar_d;
   end

endmodule

// File: rtl/hc_sr04_scanner.sv
// Round-robin HC-SR04 scanner: fires one sensor per slot, measures its echo width,
// keeps the latest result per channel and drives a bar-graph for a chosen channel.
module hc_sr04_scanner
   import hc_sr04_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
   parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
   parameter int RISE_TIMEOUT = DEF_RISE_TIMEOUT,
   parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
   parameter int RANGE_W      = 22,
   parameter int BAR_LEDS     = 18,
   parameter int BAR_STEP     = DEF_BAR_STEP
)(
   input  logic              clock,
   input  logic              reset,
   hc_sr04_scanner_if.master bus
);
   localparam int CH_W   = ch_width(CHANNELS);
   localparam int SLOT_W = $clog2(SLOT_CYCLES);
   localparam int PH_MAX = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   if (SLOT_CYCLES <= TRIG_CYCLES + RISE_TIMEOUT + ECHO_TIMEOUT + 4) begin : g_bad_slot
      $error("SLOT_CYCLES too short for trigger, rise wait and echo timeout");
   end
   if (longint'(ECHO_TIMEOUT) >= (64'd1 << RANGE_W)) begin : g_bad_range
      $error("ECHO_TIMEOUT does not fit in RANGE_W bits");
   end

   state_t              state;
   logic [CH_W-1:0]     ch, nxt_ch, done_ch;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [PH_W-1:0]     phase_cnt;
   logic [RANGE_W-1:0]  width;
   logic [CHANNELS-1:0] echo_m, echo_s, echo_d;
   logic [CHANNELS-1:0] trigger, valid, timeout;
   logic [RANGE_W-1:0]  range_r [CHANNELS];
   logic                busy, done, rise, fall;
   logic                wr_en, wr_ok;
   logic [RANGE_W-1:0]  wr_range;
   logic [RANGE_W-1:0]  sel_range;
   logic                sel_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         echo_m <= '0;
         echo_s <= '0;
         echo_d <= '0;
      end else begin
         echo_m <= bus.echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign rise   = echo_s[ch] & ~echo_d[ch];
   assign fall   = ~echo_s[ch] & echo_d[ch];
   assign nxt_ch = (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + CH_W'(1);

   // Result write: a falling edge gives a measurement, either timeout saturates.
   always_comb begin
      wr_en    = 1'b0;
      wr_ok    = 1'b0;
      wr_range = RANGE_W'(ECHO_TIMEOUT);
      case (state)
         WAIT_RISE: wr_en = !rise && (phase_cnt == PH_W'(RISE_TIMEOUT - 1));
         MEASURE: begin
            if (fall) begin
               wr_en    = 1'b1;
               wr_ok    = 1'b1;
               wr_range = width;
            end else if (width == RANGE_W'(ECHO_TIMEOUT - 1)) begin
               wr_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ch        <= '0;
         slot_cnt  <= '0;
         phase_cnt <= '0;
         width     <= '0;
         trigger   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_ch   <= '0;
         valid     <= '0;
         timeout   <= '0;
         for (int c = 0; c < CHANNELS; c++) range_r[c] <= '0;
      end else begin
         done     <= 1'b0;
         slot_cnt <= (state == IDLE) ? '0 : slot_cnt + SLOT_W'(1);
         if (wr_en) begin
            range_r[ch] <= wr_range;
            valid[ch]   <= wr_ok;
            timeout[ch] <= !wr_ok;
            done        <= 1'b1;
            done_ch     <= ch;
         end
         case (state)
            IDLE: if (bus.enable) begin
               state     <= TRIG;
               busy      <= 1'b1;
               slot_cnt  <= '0;
               phase_cnt <= '0;
               trigger   <= CHANNELS'(1) << ch;
            end
            TRIG: if (phase_cnt == PH_W'(TRIG_CYCLES - 1)) begin
               state     <= WAIT_RISE;
               trigger   <= '0;
               phase_cnt <= '0;
            end else begin
               phase_cnt <= phase_cnt + PH_W'(1);
            end
            WAIT_RISE: if (wr_en) begin
               state <= HOLDOFF;
            end else if (rise) begin
               state <= MEASURE;
               width <= RANGE_W'(1);
            end else begin
               phase_cnt <= phase_cnt + PH_W'(1);
            end
            MEASURE: if (wr_en) state <= HOLDOFF;
                     else       width <= width + RANGE_W'(1);
            // The slot always runs to completion; enable only decides what follows it.
            HOLDOFF: if (slot_cnt == SLOT_W'(SLOT_CYCLES - 1)) begin
               ch        <= nxt_ch;
               slot_cnt  <= '0;
               phase_cnt <= '0;
               if (bus.enable) begin
                  state   <= TRIG;
                  trigger <= CHANNELS'(1) << nxt_ch;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      sel_range = '0;
      sel_valid = 1'b0;
      if ({{(32 - CH_W){1'b0}}, bus.bar_sel} < 32'(CHANNELS)) begin
         sel_range = range_r[bus.bar_sel];
         sel_valid = valid[bus.bar_sel];
      end
   end

   hc_sr04_bar #(
      .RANGE_W  (RANGE_W),
      .BAR_LEDS (BAR_LEDS),
      .BAR_STEP (BAR_STEP)
   ) u_bar (
      .clock    (clock),
      .reset    (reset),
      .range_in (sel_range),
      .valid_in (sel_valid),
      .bar      (bus.bar)
   );

   for (genvar c = 0; c < CHANNELS; c++) begin : g_flat
      assign bus.range_flat[c*RANGE_W +: RANGE_W] = range_r[c];
   end

   assign bus.trigger = trigger;
   assign bus.valid   = valid;
   assign bus.timeout = timeout;
   assign bus.done    = done;
   assign bus.done_ch = done_ch;
   assign bus.busy    = busy;

endmodule

// File: doc/hc_sr04_scanner.md
Name: hc_sr04_scanner

Overview:
Multi-channel, parametrised successor to the single-sensor HC-SR04 radar. It drives CHANNELS ultrasonic sensors in round-robin time slots, so only one sensor fires at a time and sensors cannot hear each other's bursts. For each sensor it measures the echo pulse width in clock cycles and flags sensors that do not answer. It stores the latest result per channel and produces a registered bar-graph for one selectable channel. It sits between the board GPIO and the LED/display logic in the radar top level.

Parameters:
CHANNELS, 4, number of sensors scanned (>=1)
TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz)
SLOT_CYCLES, 3_000_000, clocks per channel slot, measured from trigger rise (60 ms)
RISE_TIMEOUT, 50_000, max clocks from trigger fall to echo rise
ECHO_TIMEOUT, 1_900_000, max echo high width in clocks (38 ms)
RANGE_W, 22, width of each range result
BAR_LEDS, 18, bar-graph width
BAR_STEP, 5_882, echo clocks per bar LED (~2 cm)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  scanning enabled
echo  in  CHANNELS  raw echo inputs, asynchronous
trigger  out  CHANNELS  registered trigger outputs
range_flat  out  CHANNELS*RANGE_W  per-channel last result; channel c occupies bits [c*RANGE_W +: RANGE_W]
valid  out  CHANNELS  last result of channel c was a good measurement
timeout  out  CHANNELS  last attempt of channel c timed out
done  out  1  single-cycle pulse when a channel result is written
done_ch  out  CH_W  channel index of the result, valid while done=1
busy  out  1  high in every state except IDLE
bar_sel  in  CH_W  channel shown on bar
bar  out  BAR_LEDS  thermometer bar for channel bar_sel

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is asynchronous and active-high on port `reset`. CH_W = max(1, clog2(CHANNELS)).
- Reset values: all outputs 0; state IDLE; current channel 0; all counters 0. A reset mid-slot aborts at once and trigger drops in the same cycle.
- Echo synchroniser: each echo bit passes through 2 flops, giving echo_s. Edge detection compares echo_s with its previous value.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE -> TRIG when enable=1. Entering TRIG clears slot_cnt, which then increments every cycle until the slot ends.
- TRIG: trigger[ch]=1 for exactly TRIG_CYCLES cycles; all other trigger bits are 0. Then -> WAIT_RISE.
- WAIT_RISE waits for a rising edge on echo_s[ch]. A stuck-high echo shows no edge and therefore times out.
  - Rise edge -> MEASURE, with width counter = 1.
  - RISE_TIMEOUT cycles without an edge -> write a timeout result, then HOLDOFF.
- MEASURE: the width counter increments while echo_s[ch]=1.
  - Falling edge -> write range = counter, valid=1, timeout=0, then HOLDOFF.
  - Counter reaching ECHO_TIMEOUT -> write a timeout result, then HOLDOFF.
- Timeout result: range = ECHO_TIMEOUT (saturated), valid=0, timeout=1.
- Every result write asserts done for one cycle with done_ch=ch. Results for other channels are not modified.
- HOLDOFF waits until slot_cnt = SLOT_CYCLES-1. The channel then advances, wrapping CHANNELS-1 -> 0. Next state is TRIG if enable=1, else IDLE.
- Deasserting enable mid-slot lets the current slot complete; there are no partial slots. Reasserting enable in IDLE starts at the held channel.
- Channel period is CHANNELS*SLOT_CYCLES.
- Echo edges on non-selected channels are ignored.
- Elaboration error unless SLOT_CYCLES > TRIG_CYCLES + RISE_TIMEOUT + ECHO_TIMEOUT + 4, and ECHO_TIMEOUT < 2**RANGE_W.
- bar is registered with 1-cycle latency from range/valid/bar_sel.
  - When valid[bar_sel]=1: lowest n bits set, n = min(BAR_LEDS, floor(range/BAR_STEP)+1).
  - Otherwise bar = 0.
  - Implemented as comparisons against the constants k*BAR_STEP (no divider).
  - bar_sel >= CHANNELS gives 0.

Decomposition:
- Package hc_sr04_pkg: FSM state encoding, CH_W helper function (clog2 with minimum 1), default timing constants for 50 MHz.
- Sub-module hc_sr04_bar: range + valid -> registered thermometer bar. Parameters RANGE_W, BAR_LEDS, BAR_STEP.
- Synchroniser inline.

Test Plan:
Bench parameters for all cases: CHANNELS=2, TRIG_CYCLES=10, SLOT_CYCLES=400, RISE_TIMEOUT=50, ECHO_TIMEOUT=200, BAR_STEP=20, BAR_LEDS=8.
1. Reset release with enable=1 -> trigger[0] high exactly 10 cycles and trigger[1] stays 0. trigger[1] rises 400 cycles after trigger[0] rose; trigger[0] rises again at 800.
2. ch0 echo high for 45 cycles, starting 5 cycles after trigger fall -> done pulse with done_ch=0, range0=45, valid[0]=1, timeout[0]=0. With bar_sel=0, bar=8'b0000_0111 one cycle later.
3. ch1 echo never rises -> done at 50 cycles after trigger fall, with range1=200, valid[1]=0, timeout[1]=1, bar(sel=1)=0. Channel 0 results unchanged.
4. ch0 echo held high for 300 cycles -> saturated at 200 with timeout[0]=1. The next slot still starts at cycle 400.
5. ch0 echo stuck high before the trigger -> rise timeout. Then enable dropped mid-slot -> slot completes, busy=0, IDLE; re-enable starts at channel 1.
6. Assert reset during MEASURE -> trigger, valid, timeout, range, done, bar all 0 immediately. Scanning restarts from channel 0 after release.
